// File: rtl/data_mem_split.sv
// Byte-addressed data memory with valid/ready requests and a one-cycle response pulse.
// Misaligned accesses are split into two word beats; loads are sign- or zero-extended.
module data_mem_split #(
   parameter int word_width      = 32,
   parameter int col_width       = 8,
   parameter int num_col         = word_width / col_width,
   parameter int data_addr_width = 19
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [word_width-1:0] req_addr,
   input  logic [word_width-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [word_width-1:0] rsp_rdata,
   output logic                  rsp_err,
   input  logic                  lden,
   input  logic [word_width-1:0] word_ld_addr,
   input  logic [word_width-1:0] word_ld_data
);
   localparam int off_w = $clog2(num_col);
   localparam int idx_w = data_addr_width - off_w;
   localparam int depth = 2 ** idx_w;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   state_t                          state;
   logic                            cap_we, cap_unsigned, cap_err;
   logic [1:0]                      cap_size;
   logic [off_w-1:0]                cap_off;
   logic [idx_w-1:0]                cap_idx, next_idx;
   logic [word_width-1:0]           cap_wdata, rd0, rd1;
   logic [num_col-1:0][col_width-1:0] mem [depth];

   logic [num_col-1:0]     size_lanes;
   logic [2*num_col-1:0]   lane_mask;
   logic [2*word_width-1:0] wr_wide, rd_win;
   logic                   split;
   logic [word_width-1:0]  byte_mask, top_bit, load_raw, load_data;
   logic                   mem_we;
   logic [idx_w-1:0]       wr_idx;
   logic [num_col-1:0]     wr_en;
   logic [word_width-1:0]  wr_word;

   assign req_ready = reset && (state == IDLE) && !lden;
   assign next_idx  = cap_idx + idx_w'(1);

   // Lane mask spans two words: low half is BEAT0's lanes, high half is BEAT1's.
   always_comb begin
      size_lanes = '0;
      byte_mask  = '0;
      for (int i = 0; i < num_col; i++) begin
         size_lanes[i] = (i < (1 << cap_size));
         byte_mask[i*col_width +: col_width] = {col_width{size_lanes[i]}};
      end
      lane_mask = {{num_col{1'b0}}, size_lanes} << cap_off;
      split     = |lane_mask[2*num_col-1:num_col];
      wr_wide   = {{word_width{1'b0}}, cap_wdata} << (int'(cap_off) * col_width);
      rd_win    = {rd1, rd0} >> (int'(cap_off) * col_width);
      top_bit   = byte_mask & ~(byte_mask >> 1);
      load_raw  = rd_win[word_width-1:0] & byte_mask;
      load_data = (!cap_unsigned && |(load_raw & top_bit)) ? (load_raw | ~byte_mask) : load_raw;
   end

   always_comb begin
      mem_we  = 1'b0;
      wr_idx  = cap_idx;
      wr_en   = '0;
      wr_word = wr_wide[word_width-1:0];
      case (state)
         IDLE: if (lden) begin
            mem_we  = 1'b1;
            wr_idx  = word_ld_addr[data_addr_width-1:off_w];
            wr_en   = '1;
            wr_word = word_ld_data;
         end
         BEAT0: begin
            mem_we = cap_we;
            wr_en  = lane_mask[num_col-1:0];
         end
         BEAT1: begin
            mem_we  = cap_we;
            wr_idx  = next_idx;
            wr_en   = lane_mask[2*num_col-1:num_col];
            wr_word = wr_wide[2*word_width-1:word_width];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         for (int l = 0; l < num_col; l++)
            if (wr_en[l]) mem[wr_idx][l] <= wr_word[l*col_width +: col_width];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         rd0          <= '0;
         rd1          <= '0;
         cap_we       <= 1'b0;
         cap_unsigned <= 1'b0;
         cap_err      <= 1'b0;
         cap_size     <= '0;
         cap_off      <= '0;
         cap_idx      <= '0;
         cap_wdata    <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: if (req_valid && req_ready) begin
               cap_we       <= req_we;
               cap_size     <= req_size;
               cap_unsigned <= req_unsigned;
               cap_off      <= req_addr[off_w-1:0];
               cap_idx      <= req_addr[data_addr_width-1:off_w];
               cap_wdata    <= req_wdata;
               cap_err      <= (int'(req_size) > off_w);
               state        <= (int'(req_size) > off_w) ? RESP : BEAT0;
            end
            BEAT0: begin
               if (!cap_we) rd0 <= mem[cap_idx];
               state <= split ? BEAT1 : RESP;
            end
            BEAT1: begin
               if (!cap_we) rd1 <= mem[next_idx];
               state <= RESP;
            end
            RESP: begin
               rsp_valid <= 1'b1;
               rsp_err   <= cap_err;
               rsp_rdata <= (cap_we || cap_err) ? '0 : load_data;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_split.sv
// Randomized self-checking bench for data_mem_split against a byte-array reference model.
module tb_data_mem_split;
   localparam int MB = 1 << 19;

   logic        clk = 0, reset = 0;
   logic        req_valid = 0, req_we = 0, req_unsigned = 0, lden = 0;
   logic [1:0]  req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0, word_ld_addr = 0, word_ld_data = 0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic [7:0]  bmem [MB];
   int          n_chk = 0, n_pass = 0;

   data_mem_split dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .lden(lden),
      .word_ld_addr(word_ld_addr), .word_ld_data(word_ld_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] mdl_load(input int size, input bit uns, input logic [31:0] addr);
      int nb = 1 << size;
      logic [31:0] v = 0;
      for (int i = 0; i < nb; i++) v |= 32'(bmem[(addr + 32'(i)) & (MB - 1)]) << (8 * i);
      if (!uns && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8 * nb)) - 32'd1);
      return v;
   endfunction

   task automatic mdl_store(input int size, input logic [31:0] addr, input logic [31:0] wdata);
      for (int i = 0; i < (1 << size); i++) bmem[(addr + 32'(i)) & (MB - 1)] = wdata[8*i +: 8];
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      lden = 1; word_ld_addr = addr; word_ld_data = data;
      #1 chk("ld_ready_low", {31'd0, req_ready}, 0);
      @(posedge clk);
      #1 lden = 0;
      for (int i = 0; i < 4; i++) bmem[((addr & (MB - 1)) & ~32'd3) + 32'(i)] = data[8*i +: 8];
   endtask

   task automatic xfer(input bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output bit err, output int lat);
      bit got = 0;
      rdata = 0; err = 0; lat = -1;
      @(negedge clk);
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata; req_valid = 1;
      for (int i = 0; i < 10 && !got; i++) begin
         if (req_ready) got = 1;
         else @(negedge clk);
      end
      if (!got) begin
         req_valid = 0;
         chk("accept_timeout", 0, 1);
      end else begin
         @(posedge clk);
         #1 req_valid = 0;
         for (int i = 1; i <= 10 && lat < 0; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
               lat = i - 1; rdata = rsp_rdata; err = rsp_err;
            end
         end
         if (lat < 0) chk("rsp_timeout", 0, 1);
         else begin
            @(negedge clk);
            chk("pulse_single", {31'd0, rsp_valid}, 0);
            chk("idle_rdata", rsp_rdata, 0);
         end
      end
   endtask

   task automatic run(input string tag, input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
      logic [31:0] exp_d;
      bit exp_e, e;
      int exp_lat, nb, lat;
      nb      = 1 << size;
      exp_e   = (size > 2);
      exp_lat = exp_e ? 1 : ((int'(addr & 3) + nb > 4) ? 3 : 2);
      exp_d   = (exp_e || we) ? 32'd0 : mdl_load(int'(size), uns, addr);
      xfer(we, size, uns, addr, wdata, rdata, e, lat);
      chk({tag, "_data"}, rdata, exp_d);
      chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
      chk({tag, "_lat"}, lat, exp_lat);
      if (we && !exp_e) mdl_store(int'(size), addr, wdata);
   endtask

   initial begin
      logic [31:0] d, a;
      int cnt;
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 0);
      chk("rst_valid", {31'd0, rsp_valid}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", {31'd0, rsp_err}, 0);
      reset = 1;
      @(negedge clk);
      chk("rel_ready", {31'd0, req_ready}, 1);

      preload(32'h0, 32'hdeadbeef);
      preload(32'h4, 32'h01234567);
      run("ld_w0", 0, 2, 0, 32'h0, 0, d);   chk("ld_w0_lit", d, 32'hdeadbeef);
      run("ld_b3s", 0, 0, 0, 32'h3, 0, d);  chk("ld_b3s_lit", d, 32'hffffffde);
      run("ld_b3u", 0, 0, 1, 32'h3, 0, d);  chk("ld_b3u_lit", d, 32'h000000de);
      run("ld_h0s", 0, 1, 0, 32'h0, 0, d);  chk("ld_h0s_lit", d, 32'hffffbeef);
      run("ld_w2", 0, 2, 0, 32'h2, 0, d);   chk("ld_w2_lit", d, 32'h4567dead);
      run("ld_h3u", 0, 1, 1, 32'h3, 0, d);  chk("ld_h3u_lit", d, 32'h000067de);
      run("st_h7", 1, 1, 0, 32'h7, 32'h0000cafe, d);
      run("ld_w4", 0, 2, 0, 32'h4, 0, d);   chk("ld_w4_lit", d, 32'hfe234567);
      run("ld_b8u", 0, 0, 1, 32'h8, 0, d);  chk("ld_b8u_lit", d, 32'h000000ca);
      run("ld_w0b", 0, 2, 0, 32'h0, 0, d);  chk("ld_w0b_lit", d, 32'hdeadbeef);
      preload(32'h7fffc, 32'h80000000);
      run("ld_wrap", 0, 1, 0, 32'h7ffff, 0, d); chk("ld_wrap_lit", d, 32'hffffef80);
      run("err_ld", 0, 3, 0, 32'h0, 0, d);
      run("err_st", 1, 3, 0, 32'h0, 32'hffffffff, d);
      run("ld_w0c", 0, 2, 0, 32'h0, 0, d);  chk("ld_w0c_lit", d, 32'hdeadbeef);

      // Reset during BEAT1 of a split store: only BEAT0 lanes land
      @(negedge clk);
      req_we = 1; req_size = 2; req_unsigned = 0; req_addr = 32'h6; req_wdata = 32'h11223344; req_valid = 1;
      chk("rs_ready", {31'd0, req_ready}, 1);
      @(posedge clk);
      #1 req_valid = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      #1 chk("rs_ready_low", {31'd0, req_ready}, 0);
      #1 reset = 1;
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      chk("rs_no_rsp", cnt, 0);
      chk("rs_ready_rel", {31'd0, req_ready}, 1);
      bmem[6] = 8'h44; bmem[7] = 8'h33;
      run("rs_w4", 0, 2, 0, 32'h4, 0, d);   chk("rs_w4_lit", d, 32'h33444567);
      run("rs_b8", 0, 0, 1, 32'h8, 0, d);   chk("rs_b8_lit", d, 32'h000000ca);

      // Randomized traffic over a low window and the wrapping top words
      for (int w = 0; w < 16; w++) preload(32'(w * 4), $urandom);
      preload(32'h7fff8, $urandom);
      preload(32'h7fffc, $urandom);
      for (int n = 0; n < 300; n++) begin
         logic [1:0] sz;
         a  = ($urandom_range(0, 3) == 0) ? 32'h7fff8 + $urandom_range(0, 7) : $urandom_range(0, 63);
         if ($urandom_range(0, 3) == 0) a |= $urandom & 32'hfff80000;
         sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         run("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
